// File: rtl/aes128_decrypt_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_decrypt_iter_if
//  Description : Ciphertext/key request and plaintext response handshake
//                bundle for the iterative AES-128 decryptor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes128_decrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;

    modport master (
        output in_valid, in_block, in_key, out_ready,
        input  in_ready, out_valid, out_block, busy
    );

    modport slave (
        input  in_valid, in_block, in_key, out_ready,
        output in_ready, out_valid, out_block, busy
    );
endinterface
`default_nettype wire

// File: rtl/aes128_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_decrypt_iter
//  Description : Iterative AES-128 decryptor. Expands the key schedule one
//                round key per clock (skipped when the key matches the last
//                complete schedule), then runs one inverse round per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes128_decrypt_iter #(
    parameter bit SKIP_REKEY = 1'b1
) (
    input wire                   clk,
    input wire                   rst,
    aes128_decrypt_iter_if.slave bus
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_KEYEXP = 3'd1;
    localparam logic [2:0] c_INIT   = 3'd2;
    localparam logic [2:0] c_ROUND  = 3'd3;
    localparam logic [2:0] c_FINAL  = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    logic [2:0]   r_fsm;
    logic [3:0]   r_ctr;
    logic         r_rk_valid;
    logic [127:0] r_state;
    logic [127:0] r_rk [11];

    logic [127:0] w_inv_sr_sb;
    logic [127:0] w_round_next;
    logic [127:0] w_final_next;
    logic [127:0] w_expand;

    // GF(2^8) multiply, reduction polynomial 0x11b
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^
               {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Next round key: rot/sub/rcon on the last word, then ripple the xor
    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3;
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Byte i = 4*col + row; row r of output col c comes from input col c-r
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
            o[119-32*c -: 8] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
            o[111-32*c -: 8] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
            o[103-32*c -: 8] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
        end
        return o;
    endfunction

    assign w_inv_sr_sb  = inv_shift_sub(r_state);
    assign w_round_next = inv_mix_columns(w_inv_sr_sb ^ r_rk[r_ctr]);
    assign w_final_next = w_inv_sr_sb ^ r_rk[0];
    assign w_expand     = key_expand(r_rk[r_ctr - 4'd1], rcon(r_ctr));

    assign bus.in_ready  = (r_fsm == c_IDLE);
    assign bus.busy      = (r_fsm != c_IDLE);
    assign bus.out_valid = (r_fsm == c_DONE);
    assign bus.out_block = (r_fsm == c_DONE) ? r_state : 128'h0;

    // Control FSM, key schedule and round datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm      <= c_IDLE;
            r_ctr      <= 4'd0;
            r_rk_valid <= 1'b0;
            r_state    <= '0;
            for (int i = 0; i < 11; i++) r_rk[i] <= '0;
        end else begin
            case (r_fsm)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_state <= bus.in_block;
                        if (SKIP_REKEY && r_rk_valid && (bus.in_key == r_rk[0])) begin
                            r_fsm <= c_INIT;
                        end else begin
                            // Overwriting rk[0] invalidates the stored schedule
                            r_rk[0]    <= bus.in_key;
                            r_rk_valid <= 1'b0;
                            r_ctr      <= 4'd1;
                            r_fsm      <= c_KEYEXP;
                        end
                    end
                end
                c_KEYEXP: begin
                    r_rk[r_ctr] <= w_expand;
                    r_ctr       <= r_ctr + 4'd1;
                    if (r_ctr == 4'd10) begin
                        r_rk_valid <= 1'b1;
                        r_fsm      <= c_INIT;
                    end
                end
                c_INIT: begin
                    r_state <= r_state ^ r_rk[10];
                    r_ctr   <= 4'd9;
                    r_fsm   <= c_ROUND;
                end
                c_ROUND: begin
                    r_state <= w_round_next;
                    r_ctr   <= r_ctr - 4'd1;
                    if (r_ctr == 4'd1) r_fsm <= c_FINAL;
                end
                c_FINAL: begin
                    r_state <= w_final_next;
                    r_fsm   <= c_DONE;
                end
                c_DONE: begin
                    if (bus.out_ready) r_fsm <= c_IDLE;
                end
                default: r_fsm <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes128_decrypt_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_aes128_decrypt_iter
//  Description : Self-checking bench for the iterative AES-128 decryptor,
//                with a byte-array AES-128 encryption reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_decrypt_iter;

    localparam logic [127:0] c_KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [7:0] sbox_m [256];

    aes128_decrypt_iter_if bus ();

    aes128_decrypt_iter #(.SKIP_REKEY(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from walking the multiplicative group by generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_m[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_m[0] = 8'h63;
    endtask

    // Reference AES-128 encryption on a 16-byte state, byte i = 4*col + row
    function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd+i/4][31-8*(i%4) -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // One request/response; lat = edges from accept to the first edge with out_valid high, -1 on timeout
    task automatic do_block(input logic [127:0] key, input logic [127:0] ct,
                            output logic [127:0] pt, output int lat);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_key   = key;
        bus.in_block = ct;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
        bus.in_block = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        pt  = 'x;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            bus.out_ready = 1'($urandom_range(1));
        end
        if (!bus.out_valid) begin
            lat = -1;
            bus.out_ready = 1'b0;
        end else begin
            pt = bus.out_block;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.out_block !== 128'h0) begin n_fail++; $display("FAIL reset_out_block got %h want 0", bus.out_block); end
    endtask

    task automatic test_fips_vectors();
        logic [127:0] pt;
        int lat;
        do_block(c_KEY_C1, c_CT_C1, pt, lat);
        n_checks++; if (pt !== c_PT_C1) begin n_fail++; $display("FAIL c1_pt got %h want %h", pt, c_PT_C1); end
        n_checks++; if (lat !== 22) begin n_fail++; $display("FAIL c1_latency got %0d want 22", lat); end
        do_block(c_KEY_B, c_CT_B, pt, lat);
        n_checks++; if (pt !== c_PT_B) begin n_fail++; $display("FAIL b_pt got %h want %h", pt, c_PT_B); end
        n_checks++; if (lat !== 22) begin n_fail++; $display("FAIL b_latency got %0d want 22", lat); end
    endtask

    task automatic test_key_reuse();
        logic [127:0] pt;
        int lat;
        do_block(c_KEY_B, c_CT_B, pt, lat);
        n_checks++; if (pt !== c_PT_B) begin n_fail++; $display("FAIL reuse_pt got %h want %h", pt, c_PT_B); end
        n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL reuse_latency got %0d want 12", lat); end
        do_block(c_KEY_C1, c_CT_C1, pt, lat);
        n_checks++; if (pt !== c_PT_C1) begin n_fail++; $display("FAIL rekey_pt got %h want %h", pt, c_PT_C1); end
        n_checks++; if (lat !== 22) begin n_fail++; $display("FAIL rekey_latency got %0d want 22", lat); end
    endtask

    task automatic test_back_pressure();
        int n;
        int bad;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_key   = c_KEY_C1;
        bus.in_block = c_CT_C1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reach_done got %b want 1", bus.out_valid); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_block !== c_PT_C1 || bus.in_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold unstable cycles got %0d want 0", bad); end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_single_transfer extra valid cycles got %0d want 0", bad); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt;
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_key   = c_KEY_B;
        bus.in_block = c_CT_B;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b want 1", bus.busy); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
        do_block(c_KEY_B, c_CT_B, pt, lat);
        n_checks++; if (pt !== c_PT_B) begin n_fail++; $display("FAIL midrst_pt got %h want %h", pt, c_PT_B); end
        n_checks++; if (lat !== 22) begin n_fail++; $display("FAIL midrst_latency got %0d want 22", lat); end
    endtask

    task automatic test_round_trip();
        logic [127:0] key, pt, ct, got, last_key;
        bit   have_key;
        int   lat, exp_lat;
        pulse_reset();
        have_key = 1'b0;
        last_key = '0;
        key      = {$urandom, $urandom, $urandom, $urandom};
        for (int v = 0; v < 1000; v++) begin
            if (v == 0 || $urandom_range(3) != 0) key = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = model_encrypt(key, pt);
            exp_lat = (have_key && key == last_key) ? 12 : 22;
            do_block(key, ct, got, lat);
            n_checks++; if (got !== pt) begin n_fail++; $display("FAIL rt_pt[%0d] got %h want %h", v, got, pt); end
            n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rt_latency[%0d] got %0d want %0d", v, lat, exp_lat); end
            last_key = key;
            have_key = 1'b1;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_key    = '0;
        bus.in_block  = '0;
        bus.out_ready = 1'b0;
        build_sbox();
        test_reset();
        test_fips_vectors();
        test_key_reuse();
        test_back_pressure();
        test_reset_mid();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
